// File: rtl/hex_scroll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_scroll_ctrl_pkg
// Description : Shared types and constants for the scrolling 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_scroll_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK   = 7'b1111111;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage
`default_nettype wire

// File: rtl/ascii_seg_enc.sv
`default_nettype none
// ============================================================================
// Module      : ascii_seg_enc
// Description : ASCII hex digit to active-low 7-segment encoder (combinational).
//               Define HEX_SCROLL_LOWERCASE_EN to also display 'a'-'f'.
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_seg_enc
    import hex_scroll_ctrl_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [6:0] o_seg
);

    logic [7:0] w_ch;

    always_comb begin
        w_ch = i_char;
`ifdef HEX_SCROLL_LOWERCASE_EN
        if ((i_char >= 8'h61) && (i_char <= 8'h66)) begin
            w_ch = i_char - 8'h20;
        end
`endif
    end

    always_comb begin
        o_seg = SEG_BLANK;
        case (w_ch)
            ASCII_0 + 8'd0: o_seg = 7'b1000000;
            ASCII_0 + 8'd1: o_seg = 7'b1111001;
            ASCII_0 + 8'd2: o_seg = 7'b0100100;
            ASCII_0 + 8'd3: o_seg = 7'b0110000;
            ASCII_0 + 8'd4: o_seg = 7'b0011001;
            ASCII_0 + 8'd5: o_seg = 7'b0010010;
            ASCII_0 + 8'd6: o_seg = 7'b0000010;
            ASCII_0 + 8'd7: o_seg = 7'b1111000;
            ASCII_0 + 8'd8: o_seg = 7'b0000000;
            ASCII_0 + 8'd9: o_seg = 7'b0011000;
            ASCII_A + 8'd0: o_seg = 7'b0001000;
            ASCII_A + 8'd1: o_seg = 7'b0000011;
            ASCII_A + 8'd2: o_seg = 7'b1000110;
            ASCII_A + 8'd3: o_seg = 7'b0100001;
            ASCII_A + 8'd4: o_seg = 7'b0000110;
            ASCII_A + 8'd5: o_seg = 7'b0001110;
            default:        o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_scroll_ctrl
// Description : Scrolling character buffer driving NUM_DIGITS 7-segment digits
//               through one shared encoder. Option: HEX_SCROLL_LOWERCASE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scroll_ctrl
    import hex_scroll_ctrl_pkg::*;
#(
    parameter int         NUM_DIGITS = 6,
    parameter logic [7:0] BLANK_CHAR = hex_scroll_ctrl_pkg::ASCII_SPACE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    clear,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_buf [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_clear_go;
    logic [6:0]              w_seg;

    ascii_seg_enc u_enc (
        .i_char (r_buf[r_idx]),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = (r_state == ST_IDLE) && !clear;
        w_accept     = char_valid && w_ready;
        w_clear_go   = (r_state == ST_IDLE) && clear;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_go) begin
                    w_state_next = ST_CLEAR;
                end else if (w_accept) begin
                    w_state_next = ST_REFRESH;
                end
            end
            ST_CLEAR:   w_state_next = ST_REFRESH;
            ST_REFRESH: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Buffer, refresh index and segment registers; reset also blanks the
    // display so an aborted refresh leaves no partial digits behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_hex <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buf[i] <= BLANK_CHAR;
            end
        end else begin
            if (w_clear_go) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_buf[i] <= BLANK_CHAR;
                end
                r_idx <= '0;
            end else if (w_accept) begin
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    r_buf[i] <= r_buf[i-1];
                end
                r_buf[0] <= char_in;
                r_idx    <= '0;
            end
            if (r_state == ST_CLEAR) begin
                r_idx <= '0;
            end
            if (r_state == ST_REFRESH) begin
                r_hex[7*r_idx +: 7] <= w_seg;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign char_ready = w_ready;
    assign busy       = (r_state != ST_IDLE);
    assign hex        = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scroll_ctrl
// Description : Directed self-checking bench for hex_scroll_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_ctrl;

    localparam int ND = 6;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [7:0]    char_in    = 8'h00;
    logic          char_valid = 1'b0;
    logic          clear      = 1'b0;
    logic          char_ready;
    logic [7*ND-1:0] hex;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    logic [7*ND-1:0] c_all1;
    logic [7*ND-1:0] r_exp;

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .BLANK_CHAR (8'h20)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .hex        (hex),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        while (!char_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", 64'(char_ready), 64'd1);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [7:0] ch;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [9];

    initial begin
        c_all1 = '1;
        vecs[0] = '{8'h39, 7'b0011000};
        vecs[1] = '{8'h46, 7'b0001110};
        vecs[2] = '{8'h47, 7'b1111111};
        vecs[3] = '{8'h3A, 7'b1111111};
        vecs[4] = '{8'h2F, 7'b1111111};
        vecs[5] = '{8'h30, 7'b1000000};
        vecs[6] = '{8'h41, 7'b0001000};
`ifdef HEX_SCROLL_LOWERCASE_EN
        vecs[7] = '{8'h61, 7'b0001000};
        vecs[8] = '{8'h66, 7'b0001110};
`else
        vecs[7] = '{8'h61, 7'b1111111};
        vecs[8] = '{8'h66, 7'b1111111};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hex", 64'(hex), 64'(c_all1));
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_hex", 64'(hex), 64'(c_all1));
        chk("rel_ready", 64'(char_ready), 64'd1);
        chk("rel_busy", 64'(busy), 64'd0);

        // Single char '1': latency and ignoring input during refresh
        send_char(8'h31);
        chk("t0_ready", 64'(char_ready), 64'd0);
        chk("t0_busy", 64'(busy), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                char_in    = 8'h39;
                char_valid = 1'b1;
                clear      = 1'b1;
            end else if (k == 3) begin
                char_valid = 1'b0;
                clear      = 1'b0;
            end
            chk($sformatf("t%0d_ready", k), 64'(char_ready), 64'd0);
            if (k == 1) begin
                chk("t1_dig0", 64'(hex[6:0]), 64'(7'b1111001));
                chk("t1_dig1", 64'(hex[13:7]), 64'(7'b1111111));
            end
        end
        @(posedge clk); #1;
        chk("t6_ready", 64'(char_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        r_exp = {{(7*ND-7){1'b1}}, 7'b1111001};
        chk("t6_hex", 64'(hex), 64'(r_exp));

        // Scroll "012345" then '6'; '0' falls off
        for (int i = 0; i < 7; i++) begin
            send_char(8'h30 + 8'(i));
            wait_idle();
        end
        r_exp = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
        chk("scroll_hex", 64'(hex), 64'(r_exp));

        // clear wins over a simultaneous char
        char_in    = 8'h41;
        char_valid = 1'b1;
        clear      = 1'b1;
        #1;
        chk("clr_ready", 64'(char_ready), 64'd0);
        @(posedge clk); #1;
        char_valid = 1'b0;
        clear      = 1'b0;
        chk("clr_busy", 64'(busy), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("clr6_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("clr7_busy", 64'(busy), 64'd0);
        chk("clr7_hex", 64'(hex), 64'(c_all1));
        send_char(8'h37);
        wait_idle();
        r_exp = {{(7*ND-7){1'b1}}, 7'b1111000};
        chk("clr_drop_hex", 64'(hex), 64'(r_exp));

        // Encoder boundaries and lowercase option
        foreach (vecs[i]) begin
            send_char(vecs[i].ch);
            wait_idle();
            chk($sformatf("enc_%02h", vecs[i].ch), 64'(hex[6:0]), 64'(vecs[i].seg));
        end

        // Reset during the third refresh cycle
        send_char(8'h38);
        @(posedge clk); #1;
        chk("abort_dig0", 64'(hex[6:0]), 64'(7'b0000000));
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_hex", 64'(hex), 64'(c_all1));
        chk("abort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_hex", 64'(hex), 64'(c_all1));
        chk("post_ready", 64'(char_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
